program_run_sequencer: RTL

Host-side run controller that sits directly upstream of the 9-bit processor core and drives the core's `reset` and `start` inputs. It accepts one run request at a time, pulses the core's reset and then start, waits for the core's `done`, and counts execution cycles. It returns the cycle count and a timeout flag through a valid/ready response port.

---
 rtl/run_seq_pkg.sv | 16 +
 rtl/run_cycle_counter.sv | 43 ++++
 rtl/program_run_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and widths for the program run sequencer.
package run_seq_pkg;

    localparam int CYCLE_W = 16;
    localparam int PROG_W  = 2;

    // Sequencer states: one run request is carried from IDLE back to IDLE.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CORE_RST = 3'd1,
        START    = 3'd2,
        RUN      = 3'd3,
        RESP     = 3'd4
    } run_state_t;

endpackage

// File: rtl/run_cycle_counter.sv
// Run-cycle counter with synchronous clear, count enable and a terminal flag.
// The terminal flag marks the last count before the run limit is reached, so
// the sequencer stops enabling the counter there and it never wraps.
module run_cycle_counter
    import run_seq_pkg::*;
#(
    parameter logic [CYCLE_W-1:0] MAX_CYCLES = 16'd50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               en,
    output logic [CYCLE_W-1:0] count,
    output logic               term
);

    localparam logic [CYCLE_W-1:0] LAST = MAX_CYCLES - 16'd1;

    logic [CYCLE_W-1:0] count_d, count_q;

    // Next count: clear has priority over enable.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 16'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign term  = (count_q == LAST);

endmodule

// File: rtl/program_run_sequencer.sv
// Host-side run controller for the processor core: resets the core, starts
// it, waits for done (or a cycle limit) and returns the run-cycle count
// through a valid/ready response port.
module program_run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned        RESET_CYCLES = 2,
    parameter logic [CYCLE_W-1:0] MAX_CYCLES   = 16'd50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [PROG_W-1:0]  req_prog,
    output logic [PROG_W-1:0]  core_prog,
    output logic               core_reset,
    output logic               core_start,
    input  logic               core_done,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [CYCLE_W-1:0] resp_cycles,
    output logic               resp_timeout,
    output logic               busy
);

    // Last value of the reset-cycle counter before moving to START.
    localparam logic [3:0] RST_LAST = 4'(RESET_CYCLES - 1);

    run_state_t         state_d, state_q;
    logic [3:0]         rst_cnt_d, rst_cnt_q;
    logic [PROG_W-1:0]  prog_d, prog_q;
    logic               start_d, start_q;
    logic               resp_valid_d, resp_valid_q;
    logic [CYCLE_W-1:0] cycles_d, cycles_q;
    logic               timeout_d, timeout_q;

    logic               cnt_clear;
    logic               cnt_en;
    logic [CYCLE_W-1:0] cnt;
    logic               cnt_term;

    run_cycle_counter #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .count (cnt),
        .term  (cnt_term)
    );

    // Next-state and next-output decode. core_done is only looked at in RUN,
    // which masks the done level left over from the previous run.
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        prog_d       = prog_q;
        start_d      = 1'b0;
        resp_valid_d = resp_valid_q;
        cycles_d     = cycles_q;
        timeout_d    = timeout_q;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    prog_d    = req_prog;
                    rst_cnt_d = '0;
                    state_d   = CORE_RST;
                end
            end
            CORE_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    start_d = 1'b1;
                    state_d = START;
                end else begin
                    rst_cnt_d = rst_cnt_q + 4'd1;
                end
            end
            START: begin
                cnt_clear = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                // done beats the timeout when both occur in the same cycle
                if (core_done) begin
                    cycles_d     = cnt;
                    timeout_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else if (cnt_term) begin
                    cycles_d     = MAX_CYCLES;
                    timeout_d    = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched program, start pulse and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rst_cnt_q    <= '0;
            prog_q       <= '0;
            start_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            cycles_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            prog_q       <= prog_d;
            start_q      <= start_d;
            resp_valid_q <= resp_valid_d;
            cycles_q     <= cycles_d;
            timeout_q    <= timeout_d;
        end
    end

    // The core stays in reset while this block is in reset.
    assign core_reset   = reset | (state_q == CORE_RST);
    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign core_prog    = prog_q;
    assign core_start   = start_q;
    assign resp_valid   = resp_valid_q;
    assign resp_cycles  = cycles_q;
    assign resp_timeout = timeout_q;

endmodule
